store_rmw_unit: RTL
===================

Name: store_rmw_unit

Overview:
- Write-side counterpart of the load sign/zero-extension path in the MEM stage.
- Takes word, halfword and byte stores from the EXE/MEM register and commits them to a word-only data RAM.
- Word stores are written directly. Sub-word stores use read-modify-write: read the word, merge the lane, write it back.
- Holds the pipeline through store_stall until the store is committed.

Parameters:
- RAM_RD_LAT, 1, cycles from RAM_re to valid RAM_rdata (legal 1..3).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- EXE_MEM_mem_w  in  1  store request; held stable while store_stall=1
- EXE_MEM_STORE_type  in  2  00=word, 10=halfword, 01=byte (same encoding as the load type)
- EXE_MEM_addr  in  ADDR_W  byte address
- EXE_MEM_store_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- RAM_rdata  in  32  RAM read data
- RAM_addr  out  ADDR_W  word-aligned address ([1:0]=00)
- RAM_wdata  out  32  merged write word
- RAM_we  out  1  write strobe, one cycle per store
- RAM_re  out  1  read strobe, one cycle per sub-word store
- store_stall  out  1  combinational: EXE_MEM_mem_w & ~store_done
- store_done  out  1  one-cycle pulse when the store completes (written or rejected)
- store_misalign  out  1  one-cycle pulse coincident with store_done for rejected stores

Behaviour:
- Reset values: all registered outputs 0, state=IDLE, wait counter 0. Reset mid-operation aborts the store; RAM_we/RAM_re drop asynchronously and no partial write occurs.
- Outputs are registered except store_stall. RAM_addr and RAM_wdata are 0 when neither strobe is asserted.
- Lanes are little-endian. The byte lane is addr[1:0]. The half lane is addr[1] (0 = [15:0], 1 = [31:16]).
- Misaligned cases:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=00.
- States:
  - IDLE: if EXE_MEM_mem_w=1, latch addr, type and data, then:
    - misaligned -> ERR;
    - type 00 -> WRITE with wdata = store_data;
    - type 11 (reserved) -> treated as word;
    - else -> READ.
  - READ: RAM_re=1 and RAM_addr driven for this cycle; load wait counter with RAM_RD_LAT; go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, capture RAM_rdata on that edge, merge the latched data into the selected lane (other lanes preserved), and go to WRITE.
  - WRITE: RAM_we=1, RAM_addr and RAM_wdata valid, store_done=1; go to IDLE.
  - ERR: store_done=1, store_misalign=1, no RAM strobe; go to IDLE.
- Latency from accept to store_done: word 1 cycle; sub-word RAM_RD_LAT+2 cycles; misaligned 1 cycle.
- Requests are accepted only in IDLE. A new request in the cycle after store_done is accepted normally, giving back-to-back stores with no idle bubble.
- Requests that change while stalled are a protocol violation. The latched copy is used, and the bench flags the violation.
- Store data bits above the selected width are ignored.

Decomposition:
- Shared package holds:
  - store/load type constants (MEM_WORD=2'b00, MEM_HALF=2'b10, MEM_BYTE=2'b01);
  - the state enum (IDLE, READ, WAIT, WRITE, ERR).
- One natural sub-module, store_lane_merge: combinational (old_word, data, type, addr[1:0]) -> merged word. It mirrors the lane selection of the load-extend path.

Test Plan:
- Word store, addr=0x100, data=0xDEADBEEF:
  - next cycle RAM_we=1, RAM_addr=0x100, RAM_wdata=0xDEADBEEF, store_done=1;
  - store_stall high for exactly 1 cycle.
- Byte store, addr=0x203, data=0x000000AB, RAM word 0x11223344, RAM_RD_LAT=1:
  - RAM_re at cycle+1, RAM_we at cycle+3 with RAM_wdata=0xAB223344;
  - store_stall high 3 cycles.
- Halfword store, addr=0x202, data=0xFFFF5A5A, RAM word 0x11223344 -> RAM_wdata=0x5A5A3344. Repeat with RAM_RD_LAT=3 -> RAM_we at cycle+5.
- Misaligned halfword, addr=0x201 -> store_done and store_misalign pulse at cycle+1, RAM_we and RAM_re never asserted.
- Back-to-back byte stores to 0x300 and 0x301 (data 0x01, 0x02), initial word 0 -> final word 0x00000201. The second read returns the first write's result.
- rst asserted during WAIT of a byte store -> RAM_we stays 0, store_done stays 0, state IDLE; the RAM word is unchanged after release.

Source files
------------

// File: rtl/store_rmw_unit_pkg.sv
// Shared definitions for the MEM-stage store path.
// Holds the memory access type encoding (shared with the load-extend
// path), the store controller state enum and an alignment helper.
package store_rmw_unit_pkg;

  // Access width encoding, identical to the load type field.
  localparam logic [1:0] MEM_WORD = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_BYTE = 2'b01;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } store_state_e;

  // The reserved type 2'b11 behaves as a word store, so it carries
  // word alignment rules as well.
  function automatic logic store_misaligned(input logic [1:0] mem_type,
                                            input logic [1:0] lane_addr);
    logic mis;
    mis = 1'b0;
    case (mem_type)
      MEM_HALF: mis = lane_addr[0];
      MEM_BYTE: mis = 1'b0;
      default:  mis = (lane_addr != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge for sub-word stores.
// Inserts the right-aligned store data into the addressed little-endian
// lane of the old RAM word and keeps every other lane unchanged. Lane
// selection matches the load-extend path: byte lane = lane_addr[1:0],
// half lane = lane_addr[1]. Word (and reserved) types pass data through.
// Ports:
//   old_word  - word read back from the RAM
//   data      - store data, right-aligned; bits above the width ignored
//   mem_type  - access type (MEM_WORD / MEM_HALF / MEM_BYTE)
//   lane_addr - byte address bits [1:0]
//   merged    - word to be written back
module store_lane_merge
  import store_rmw_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  mem_type,
  input  logic [1:0]  lane_addr,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (mem_type)
      MEM_BYTE: begin
        case (lane_addr)
          2'd0: merged[7:0]   = data[7:0];
          2'd1: merged[15:8]  = data[7:0];
          2'd2: merged[23:16] = data[7:0];
          2'd3: merged[31:24] = data[7:0];
          default: merged = old_word;
        endcase
      end
      MEM_HALF: begin
        if (lane_addr[1]) merged[31:16] = data[15:0];
        else              merged[15:0]  = data[15:0];
      end
      default: merged = data;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// MEM-stage store unit in front of a word-only data RAM.
// Word stores are written in one cycle; byte/half stores read the word,
// merge the lane and write it back; misaligned stores are rejected.
//
// Handshake: EXE_MEM_mem_w acts as "valid" and must be held, with type,
// addr and data stable, until store_done. store_stall (= mem_w & ~done)
// is the inverse of "ready": the pipeline advances at the end of the
// cycle in which store_done is high. A request is only accepted in IDLE,
// and a new one in the cycle after store_done is taken without a bubble.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   EXE_MEM_mem_w       - store request
//   EXE_MEM_STORE_type  - 00 word, 10 half, 01 byte (11 treated as word)
//   EXE_MEM_addr        - byte address
//   EXE_MEM_store_data  - right-aligned store data
//   RAM_rdata           - RAM read data, valid RAM_RD_LAT cycles after RAM_re
//   RAM_addr/RAM_wdata  - word-aligned address / write word (0 when no strobe)
//   RAM_we / RAM_re     - one-cycle write / read strobes
//   store_stall         - combinational pipeline hold
//   store_done          - one-cycle completion pulse (written or rejected)
//   store_misalign      - one-cycle pulse with store_done for rejected stores
//   dbg_state           - current controller state for observation
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int RAM_RD_LAT = 1,
  parameter int ADDR_W     = 32
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              EXE_MEM_mem_w,
  input  logic [1:0]        EXE_MEM_STORE_type,
  input  logic [ADDR_W-1:0] EXE_MEM_addr,
  input  logic [31:0]       EXE_MEM_store_data,
  input  logic [31:0]       RAM_rdata,
  output logic [ADDR_W-1:0] RAM_addr,
  output logic [31:0]       RAM_wdata,
  output logic              RAM_we,
  output logic              RAM_re,
  output logic              store_stall,
  output logic              store_done,
  output logic              store_misalign,
  output store_state_e      dbg_state
);

  localparam logic [1:0] LAT_LOAD = 2'(RAM_RD_LAT);

  store_state_e      state, next_state;
  logic [1:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_type;
  logic [31:0]       lat_data;
  logic              accept;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       merged;
  logic              we_d, re_d, done_d, mis_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;

  assign accept      = (state == IDLE) && EXE_MEM_mem_w;
  assign store_stall = EXE_MEM_mem_w & ~store_done;
  assign dbg_state   = state;

  // In IDLE the request has not been latched yet, so the outgoing address
  // for the first strobe comes straight from the pipeline register.
  assign req_addr  = (state == IDLE) ? EXE_MEM_addr : lat_addr;
  assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

  store_lane_merge u_lane_merge (
    .old_word  (RAM_rdata),
    .data      (lat_data),
    .mem_type  (lat_type),
    .lane_addr (lat_addr[1:0]),
    .merged    (merged)
  );

  // Next state, then the registered outputs decoded from the state being
  // entered so that each strobe is valid for exactly that state's cycle.
  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    we_d       = 1'b0;
    re_d       = 1'b0;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    addr_d     = '0;
    wdata_d    = '0;

    case (state)
      IDLE: begin
        if (EXE_MEM_mem_w) begin
          if (store_misaligned(EXE_MEM_STORE_type, EXE_MEM_addr[1:0]))
            next_state = ERR;
          else if (EXE_MEM_STORE_type == MEM_HALF || EXE_MEM_STORE_type == MEM_BYTE)
            next_state = READ;
          else
            next_state = WRITE;
        end
      end
      READ: begin
        cnt_d      = LAT_LOAD;
        next_state = WAIT;
      end
      WAIT: begin
        // Counter value 1 marks the cycle in which RAM_rdata is valid.
        cnt_d = cnt - 2'd1;
        if (cnt == 2'd1) next_state = WRITE;
      end
      WRITE:   next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase

    case (next_state)
      READ: begin
        re_d   = 1'b1;
        addr_d = word_addr;
      end
      WRITE: begin
        we_d    = 1'b1;
        done_d  = 1'b1;
        addr_d  = word_addr;
        wdata_d = (state == IDLE) ? EXE_MEM_store_data : merged;
      end
      ERR: begin
        done_d = 1'b1;
        mis_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 2'd0;
      lat_addr       <= '0;
      lat_type       <= 2'b00;
      lat_data       <= 32'h0;
      RAM_addr       <= '0;
      RAM_wdata      <= 32'h0;
      RAM_we         <= 1'b0;
      RAM_re         <= 1'b0;
      store_done     <= 1'b0;
      store_misalign <= 1'b0;
    end else begin
      state          <= next_state;
      cnt            <= cnt_d;
      RAM_addr       <= addr_d;
      RAM_wdata      <= wdata_d;
      RAM_we         <= we_d;
      RAM_re         <= re_d;
      store_done     <= done_d;
      store_misalign <= mis_d;
      if (accept) begin
        lat_addr <= EXE_MEM_addr;
        lat_type <= EXE_MEM_STORE_type;
        lat_data <= EXE_MEM_store_data;
      end
    end
  end

endmodule
